// File: rtl/lw_cipher_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : lw_cipher_core_if
//  Brief    : Input/output handshake bundle of the lightweight cipher core.
//  Revision : 1.0 - initial release
// ============================================================================
interface lw_cipher_core_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] key;
    logic              enc_dec;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              busy;

    modport master (
        output in_valid, data_in, key, enc_dec, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, key, enc_dec, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/lw_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module   : lw_cipher_core
//  Brief    : Iterative XOR/rotate block cipher, one round per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module lw_cipher_core #(
    parameter int DATA_W = 128,
    parameter int ROUNDS = 10,
    parameter int ROT    = 8
) (
    input  logic            clk,
    input  logic            rst,
    lw_cipher_core_if.slave cif
);
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_keyx   = 2'd1;
    localparam logic [1:0] c_round  = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;
    localparam logic [7:0] c_rounds = 8'(ROUNDS);
    localparam logic [7:0] c_last   = 8'(ROUNDS - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] r_key;
    logic              r_enc;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [DATA_W-1:0] r_data_out;

    logic [7:0]        w_dec_idx;
    logic [DATA_W-1:0] w_cnt_ext;
    logic [DATA_W-1:0] w_dec_ext;
    logic [DATA_W-1:0] w_key_fwd;
    logic [DATA_W-1:0] w_key_bwd_x;
    logic [DATA_W-1:0] w_key_bwd;
    logic [DATA_W-1:0] w_enc_x;
    logic [DATA_W-1:0] w_enc_s;
    logic [DATA_W-1:0] w_dec_s;

    assign w_dec_idx   = c_last - r_cnt;
    assign w_cnt_ext   = {{(DATA_W-8){1'b0}}, r_cnt};
    assign w_dec_ext   = {{(DATA_W-8){1'b0}}, w_dec_idx};

    // Forward schedule serves both KEYX and encrypt; decrypt walks it backwards
    // from k(ROUNDS) so only one key register is ever needed.
    assign w_key_fwd   = {r_key[DATA_W-2:0], r_key[DATA_W-1]} ^ w_cnt_ext;
    assign w_key_bwd_x = r_key ^ w_dec_ext;
    assign w_key_bwd   = {w_key_bwd_x[0], w_key_bwd_x[DATA_W-1:1]};

    assign w_enc_x     = r_s ^ r_key;
    assign w_enc_s     = {w_enc_x[DATA_W-1-ROT:0], w_enc_x[DATA_W-1 -: ROT]};
    assign w_dec_s     = {r_s[ROT-1:0], r_s[DATA_W-1:ROT]} ^ w_key_bwd;

    assign cif.in_ready  = r_in_ready;
    assign cif.out_valid = r_out_valid;
    assign cif.busy      = r_busy;
    assign cif.data_out  = r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_cnt       <= '0;
            r_s         <= '0;
            r_key       <= '0;
            r_enc       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (cif.in_valid) begin
                        r_s        <= cif.data_in;
                        r_key      <= cif.key;
                        r_enc      <= cif.enc_dec;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= cif.enc_dec ? c_round : c_keyx;
                    end
                end
                c_keyx: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= c_round;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_round: begin
                    // Count reaching ROUNDS is the write-back cycle into data_out.
                    if (r_cnt == c_rounds) begin
                        r_data_out  <= r_s;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_done;
                    end else begin
                        r_s   <= r_enc ? w_enc_s : w_dec_s;
                        r_key <= r_enc ? w_key_fwd : w_key_bwd;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_done: begin
                    if (cif.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lw_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lw_cipher_core
//  Brief    : Self-checking bench: directed small-core cases plus randomized
//             round trips on the default core against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lw_cipher_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   nprint   = 0;

    always #5 clk = ~clk;

    lw_cipher_core_if #(.DATA_W(32))  s_if ();
    lw_cipher_core_if #(.DATA_W(128)) b_if ();

    lw_cipher_core #(.DATA_W(32), .ROUNDS(1), .ROT(8)) dut_s (
        .clk (clk),
        .rst (rst),
        .cif (s_if.slave)
    );

    lw_cipher_core dut_b (
        .clk (clk),
        .rst (rst),
        .cif (b_if.slave)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
            end
        end
    endtask

    function automatic logic [255:0] m_rotl(input logic [255:0] x, input int w, input int n);
        logic [255:0] y = '0;
        for (int i = 0; i < w; i++) y[(i + n) % w] = x[i];
        return y;
    endfunction

    // Reference cipher straight from the round definitions, keeping every
    // round key in a table.
    function automatic logic [255:0] m_cipher(input logic [255:0] d, input logic [255:0] k,
                                              input bit enc, input int w, input int rounds,
                                              input int rot);
        logic [255:0] ks [0:256];
        logic [255:0] s;
        ks[0] = k;
        for (int r = 0; r < rounds; r++) ks[r+1] = m_rotl(ks[r], w, 1) ^ 256'(r);
        s = d;
        if (enc) begin
            for (int r = 0; r < rounds; r++) s = m_rotl(s ^ ks[r], w, rot);
        end else begin
            for (int r = rounds - 1; r >= 0; r--) s = m_rotl(s, w, w - rot) ^ ks[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Transaction-level expectation for the default core, checked every cycle.
    initial begin : compare
        bit           m_init = 1'b0;
        bit           m_busy = 1'b0;
        logic [255:0] m_res  = '0;
        logic [127:0] m_dout = '0;
        longint       cyc    = 0;
        longint       m_due  = 0;
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("cmp_in_ready",  b_if.in_ready,  !m_busy);
                chk("cmp_busy",      b_if.busy,      m_busy);
                chk("cmp_out_valid", b_if.out_valid, m_busy && (cyc >= m_due));
                chk("cmp_data_out",  b_if.data_out,  m_dout);
            end
            if (rst) begin
                m_init = 1'b1;
                m_busy = 1'b0;
                m_dout = '0;
            end else if (m_init) begin
                if (!m_busy) begin
                    if (b_if.in_valid) begin
                        m_busy = 1'b1;
                        m_res  = m_cipher(b_if.data_in, b_if.key, b_if.enc_dec, 128, 10, 8);
                        m_due  = cyc + 1 + (b_if.enc_dec ? 11 : 21);
                    end
                end else if (cyc >= m_due) begin
                    if (b_if.out_ready) m_busy = 1'b0;
                end else if (cyc + 1 == m_due) begin
                    m_dout = m_res[127:0];
                end
            end
            cyc++;
        end
    end

    task automatic s_run(input logic [31:0] d, input logic [31:0] k, input bit enc,
                         input int lat, input logic [31:0] exp);
        int n;
        s_if.in_valid = 1'b1;
        s_if.data_in  = d;
        s_if.key      = k;
        s_if.enc_dec  = enc;
        chk("s_in_ready_idle", s_if.in_ready, 1'b1);
        @(posedge clk); #1;
        s_if.in_valid = 1'b0;
        s_if.data_in  = ~d;
        s_if.key      = ~k;
        s_if.enc_dec  = !enc;
        n = 0;
        while (!s_if.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_latency", n, lat);
        chk("s_data_out", s_if.data_out, exp);
        chk("s_in_ready_done", s_if.in_ready, 1'b0);
        s_if.out_ready = 1'b1;
        @(posedge clk); #1;
        s_if.out_ready = 1'b0;
        chk("s_back_idle", s_if.in_ready, 1'b1);
        chk("s_valid_drop", s_if.out_valid, 1'b0);
    endtask

    task automatic b_toggle();
        b_if.data_in  = rnd128();
        b_if.key      = rnd128();
        b_if.enc_dec  = ~b_if.enc_dec;
        b_if.in_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic b_xact(input logic [127:0] d, input logic [127:0] k, input bit enc,
                          input int hold, input logic [127:0] exp, input int lat);
        int n;
        b_if.in_valid  = 1'b1;
        b_if.data_in   = d;
        b_if.key       = k;
        b_if.enc_dec   = enc;
        b_if.out_ready = 1'($urandom_range(0, 1));
        n = 0;
        while (!b_if.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_in_ready", b_if.in_ready, 1'b1);
        @(posedge clk); #1;
        n = 0;
        while (!b_if.out_valid && n < 100) begin
            b_toggle();
            b_if.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("b_latency", n, lat);
        chk("b_result", b_if.data_out, exp);
        b_if.out_ready = 1'b0;
        repeat (hold) begin
            b_toggle();
            @(posedge clk); #1;
            chk("b_hold_valid", b_if.out_valid, 1'b1);
            chk("b_hold_data", b_if.data_out, exp);
            chk("b_hold_in_ready", b_if.in_ready, 1'b0);
        end
        b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        b_if.out_ready = 1'b0;
        b_if.in_valid  = 1'b0;
        chk("b_back_idle", b_if.in_ready, 1'b1);
    endtask

    task automatic b_abort(input bit enc, input int n);
        int seen = 0;
        b_if.in_valid = 1'b1;
        b_if.data_in  = rnd128();
        b_if.key      = rnd128();
        b_if.enc_dec  = enc;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", b_if.in_ready, 1'b1);
        chk("abort_data_out", b_if.data_out, 128'd0);
        chk("abort_out_valid", b_if.out_valid, 1'b0);
        chk("abort_busy", b_if.busy, 1'b0);
        repeat (30) begin
            @(posedge clk); #1;
            if (b_if.out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [127:0] x, kk, ct;
        logic [255:0] full;
        int           hold;
        s_if.in_valid = 1'b0; s_if.data_in = '0; s_if.key = '0;
        s_if.enc_dec  = 1'b0; s_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.data_in = '0; b_if.key = '0;
        b_if.enc_dec  = 1'b0; b_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_s_in_ready",  s_if.in_ready,  1'b1);
        chk("rst_s_out_valid", s_if.out_valid, 1'b0);
        chk("rst_s_busy",      s_if.busy,      1'b0);
        chk("rst_s_data_out",  s_if.data_out,  32'h0);
        chk("rst_b_data_out",  b_if.data_out,  128'h0);

        chk("pin_enc_1",     m_cipher(256'h1, 256'h0, 1'b1, 32, 1, 8), 256'h100);
        chk("pin_enc_ff",    m_cipher(256'h0, 256'hFF, 1'b1, 32, 1, 8), 256'hFF00);
        chk("pin_dec_ff",    m_cipher(256'hFF00, 256'hFF, 1'b0, 32, 1, 8), 256'h0);
        chk("pin_enc_2rnd",  m_cipher(256'h0, 256'h1, 1'b1, 32, 2, 8), 256'h10200);

        s_run(32'h0000_0001, 32'h0000_0000, 1'b1, 2, 32'h0000_0100);
        s_run(32'h0000_0000, 32'h0000_00FF, 1'b1, 2, 32'h0000_FF00);
        s_run(32'h0000_FF00, 32'h0000_00FF, 1'b0, 3, 32'h0000_0000);

        for (int i = 0; i < 1000; i++) begin
            x    = rnd128();
            kk   = rnd128();
            full = m_cipher(x, kk, 1'b1, 128, 10, 8);
            ct   = full[127:0];
            hold = (i % 50 == 0) ? 5 : int'($urandom_range(0, 2));
            b_xact(x,  kk, 1'b1, hold, ct, 11);
            b_xact(ct, kk, 1'b0, hold, x,  21);
        end

        b_abort(1'b1, 5);
        b_abort(1'b0, 5);
        b_abort(1'b0, 15);

        x  = rnd128();
        kk = rnd128();
        full = m_cipher(x, kk, 1'b0, 128, 10, 8);
        b_xact(x, kk, 1'b0, 5, full[127:0], 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
